fetch_ctrl: RTL

Front-end fetch sequencer that drives the program counter into the two-stage instruction fetch unit and collects the instructions it returns. It tracks every in-flight fetch and buffers returned instructions in a small FIFO. A credit check guarantees no instruction is ever dropped under decode back-pressure. A redirect from the back end (branch mispredict or exception) steers the PC and squashes all stale work.

---
 rtl/fetch_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - front-end fetch sequencer with in-flight tracking and fetch queue
//
// Issues a PC to the two-stage fetch unit every cycle, tracks which of those
// PCs are real fetches, and buffers returned instructions in a small FIFO
// toward decode. A credit check keeps the FIFO from overflowing; a redirect
// steers the PC and squashes all queued and in-flight work.
//
// Ports:
//   clk               clock
//   reset             asynchronous, active-high reset
//   fetch_pc_o        PC presented to the fetch unit (sampled every rising edge)
//   fetch_instr_i     instruction returned FETCH_LAT cycles after its PC
//   redirect_valid_i  one-cycle redirect strobe
//   redirect_pc_i     redirect target (word-aligned)
//   dec_valid_o       fetch-queue head valid
//   dec_ready_i       decode accepts the head
//   dec_instr_o       head instruction
//   dec_pc_o          head PC

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          FQ_DEPTH  = 4,
  parameter int          FETCH_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] fetch_pc_o,
  input  logic [31:0] fetch_instr_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [31:0] dec_instr_o,
  output logic [31:0] dec_pc_o
);

  localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam logic [CW-1:0] FQ_FULL_C  = CW'(FQ_DEPTH);
  localparam logic [CW:0]   FQ_LIMIT_C = (CW + 1)'(FQ_DEPTH);

  // Next PC to issue
  logic [31:0] pc_q, pc_d;

  // In-flight shift register: stage 0 is the PC issued last cycle
  logic [FETCH_LAT-1:0] pipe_v_q, pipe_v_d;
  logic [31:0]          pipe_pc_q [FETCH_LAT];

  // Fetch queue
  logic [31:0]   fifo_pc_q    [FQ_DEPTH];
  logic [31:0]   fifo_instr_q [FQ_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [CW-1:0] inflight;
  logic [CW:0]   credit_used;
  logic          issue;
  logic          push;
  logic          pop;

  assign fetch_pc_o  = pc_q;
  assign dec_valid_o = (count_q != '0);
  assign dec_pc_o    = fifo_pc_q[rd_ptr_q];
  assign dec_instr_o = fifo_instr_q[rd_ptr_q];

  always_comb begin
    inflight = '0;
    for (int k = 0; k < FETCH_LAT; k++) begin
      inflight = inflight + {{(CW-1){1'b0}}, pipe_v_q[k]};
    end
  end

  // Credit counts everything queued or on its way back. A dequeue this cycle
  // is not credited, so the sum can never exceed the queue depth at capture.
  assign credit_used = {1'b0, count_q} + {1'b0, inflight};
  assign issue       = !redirect_valid_i && (credit_used < FQ_LIMIT_C);
  assign push        = pipe_v_q[FETCH_LAT-1] && !redirect_valid_i;
  assign pop         = dec_valid_o && dec_ready_i;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i;
    end else if (issue) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_comb begin
    pipe_v_d    = '0;
    pipe_v_d[0] = issue;
    for (int k = 1; k < FETCH_LAT; k++) begin
      pipe_v_d[k] = pipe_v_q[k-1] && !redirect_valid_i;
    end
  end

  // A redirect empties the queue; a head handshaken in the same cycle has
  // already been taken by decode, so no extra handling is needed for it.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      pipe_v_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < FETCH_LAT; k++) begin
        pipe_pc_q[k] <= '0;
      end
      for (int i = 0; i < FQ_DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else begin
      pc_q         <= pc_d;
      pipe_v_q     <= pipe_v_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      pipe_pc_q[0] <= pc_q;
      for (int k = 1; k < FETCH_LAT; k++) begin
        pipe_pc_q[k] <= pipe_pc_q[k-1];
      end
      if (push) begin
        fifo_pc_q[wr_ptr_q]    <= pipe_pc_q[FETCH_LAT-1];
        fifo_instr_q[wr_ptr_q] <= fetch_instr_i;
      end
    end
  end

  // The credit rule makes a push into a full queue impossible.
  ap_no_push_full: assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == FQ_FULL_C)));

endmodule
